// File: rtl/tm1638_pkg.sv
// Shared types and constants for the framed TM1638 transaction engine.
package tm1638_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_SETUP  = 4'd1,
    ST_CMD    = 4'd2,
    ST_WFETCH = 4'd3,
    ST_WBYTE  = 4'd4,
    ST_RWAIT  = 4'd5,
    ST_RBYTE  = 4'd6,
    ST_HOLD   = 4'd7,
    ST_GAP    = 4'd8
  } state_t;

  localparam logic [7:0] CMD_DATA_WR_AUTO = 8'h40;
  localparam logic [7:0] CMD_DATA_RD_KEYS = 8'h42;
  localparam logic [7:0] CMD_ADDR_BASE    = 8'hC0;
  localparam logic [7:0] CMD_DISP_ON      = 8'h88;

  localparam int KEY_BYTES = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tm1638_shift.sv
// 8-bit LSB-first serialiser/deserialiser with the sclk half-period counter.
// A byte is sclk low CLK_DIV clocks then high CLK_DIV clocks per bit; sclk idles high.
module tm1638_shift #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] byte_in,
  input  logic       dir,
  output logic       sclk,
  output logic       dio_out,
  input  logic       dio_in,
  output logic [7:0] byte_out,
  output logic       byte_done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic             active_r;
  logic             high_r;
  logic [DIV_W-1:0] div_r;
  logic [2:0]       bit_r;
  logic [7:0]       sreg_r;
  logic             phase_end_s;

  assign phase_end_s = active_r && (div_r == DIV_LAST);
  assign byte_done   = phase_end_s && high_r && (bit_r == 3'd7);

  // Bit sequencing: sclk falls with each new bit, read samples shift in at the end of the high phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_r <= 1'b0;
      high_r   <= 1'b0;
      div_r    <= '0;
      bit_r    <= 3'd0;
      sreg_r   <= 8'h00;
      sclk     <= 1'b1;
      dio_out  <= 1'b1;
    end else if (load) begin
      active_r <= 1'b1;
      high_r   <= 1'b0;
      div_r    <= '0;
      bit_r    <= 3'd0;
      sreg_r   <= {1'b0, byte_in[7:1]};
      sclk     <= 1'b0;
      dio_out  <= dir ? 1'b1 : byte_in[0];
    end else if (active_r) begin
      if (div_r == DIV_LAST) begin
        div_r <= '0;
        if (!high_r) begin
          high_r <= 1'b1;
          sclk   <= 1'b1;
        end else begin
          sreg_r <= {dio_in, sreg_r[7:1]};
          if (bit_r == 3'd7) begin
            active_r <= 1'b0;
          end else begin
            bit_r   <= bit_r + 3'd1;
            high_r  <= 1'b0;
            sclk    <= 1'b0;
            dio_out <= dir ? 1'b1 : sreg_r[0];
          end
        end
      end else begin
        div_r <= div_r + DIV_W'(1);
      end
    end else begin
      sclk <= 1'b1;
    end
  end

  // Completed read byte, held until the next read byte completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_out <= 8'h00;
    end else if (byte_done && dir) begin
      byte_out <= {dio_in, sreg_r[7:1]};
    end else begin
      byte_out <= byte_out;
    end
  end

endmodule

// File: rtl/tm1638_xfer.sv
// Framed TM1638 transaction engine: STB low, command byte, N payload bytes, STB high.
// Define TM1638_XFER_RD_SYNC_EN to pass dio_in through a 2-flop synchroniser (needs CLK_DIV>=3).
module tm1638_xfer
  import tm1638_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int MAX_LEN  = 16,
  parameter int LEN_W    = 5,
  parameter int WAIT_CYC = 8,
  parameter int STB_GAP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             rw,
  input  logic [7:0]       cmd,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             stb,
  output logic             sclk,
  output logic             dio_out,
  output logic             dio_oe,
  input  logic             dio_in
);

  localparam int CNT_MAX = max3(CLK_DIV, WAIT_CYC, STB_GAP);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STB_GAP - 1);
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [LEN_W-1:0] rem_r;
  logic             rw_r;
  logic [7:0]       cmd_r;
  logic             armed_r;

  logic             load_s;
  logic [7:0]       byte_in_s;
  logic             dir_s;
  logic             byte_done_s;
  logic             din_s;

`ifdef TM1638_XFER_RD_SYNC_EN
  logic [1:0] sync_r;

  // Two-stage synchroniser on the chip's data line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], dio_in};
    end
  end

  assign din_s = sync_r[1];
`else
  assign din_s = dio_in;
`endif

  // Shifter control: when a byte starts, what it carries and which direction
  always_comb begin
    load_s    = 1'b0;
    byte_in_s = cmd_r;
    dir_s     = 1'b0;
    case (state_r)
      ST_SETUP:  load_s = (cnt_r == DIV_LAST);
      ST_WFETCH: begin
        load_s    = wr_valid;
        byte_in_s = wr_data;
      end
      ST_RWAIT: begin
        dir_s  = 1'b1;
        load_s = (cnt_r == WAIT_LAST);
      end
      ST_RBYTE: begin
        dir_s  = 1'b1;
        load_s = byte_done_s && (rem_r != LEN_ONE);
      end
      default: load_s = 1'b0;
    endcase
  end

  assign wr_ready = (state_r == ST_WFETCH) && wr_valid;

  // Transaction sequencer; armed_r drops a start that coincides with reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      rem_r    <= '0;
      rw_r     <= 1'b0;
      cmd_r    <= 8'h00;
      armed_r  <= 1'b0;
      stb      <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      dio_oe   <= 1'b1;
      rd_valid <= 1'b0;
    end else begin
      armed_r  <= 1'b1;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start && armed_r) begin
            cmd_r   <= cmd;
            rw_r    <= rw;
            rem_r   <= (len > LEN_MAX) ? LEN_MAX : len;
            cnt_r   <= '0;
            stb     <= 1'b0;
            busy    <= 1'b1;
            state_r <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt_r == DIV_LAST) begin
            cnt_r   <= '0;
            state_r <= ST_CMD;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_CMD: begin
          if (byte_done_s) begin
            cnt_r <= '0;
            if (rem_r == '0) begin
              state_r <= ST_HOLD;
            end else if (!rw_r) begin
              state_r <= ST_WFETCH;
            end else begin
              dio_oe  <= 1'b0;
              state_r <= ST_RWAIT;
            end
          end
        end
        ST_WFETCH: begin
          if (wr_valid) begin
            state_r <= ST_WBYTE;
          end
        end
        ST_WBYTE: begin
          if (byte_done_s) begin
            rem_r   <= rem_r - LEN_ONE;
            cnt_r   <= '0;
            state_r <= (rem_r == LEN_ONE) ? ST_HOLD : ST_WFETCH;
          end
        end
        ST_RWAIT: begin
          if (cnt_r == WAIT_LAST) begin
            cnt_r   <= '0;
            state_r <= ST_RBYTE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_RBYTE: begin
          if (byte_done_s) begin
            rd_valid <= 1'b1;
            rem_r    <= rem_r - LEN_ONE;
            cnt_r    <= '0;
            state_r  <= (rem_r == LEN_ONE) ? ST_HOLD : ST_RBYTE;
          end
        end
        ST_HOLD: begin
          if (cnt_r == DIV_LAST) begin
            cnt_r   <= '0;
            stb     <= 1'b1;
            dio_oe  <= 1'b1;
            state_r <= ST_GAP;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (cnt_r == GAP_LAST) begin
            cnt_r   <= '0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          cnt_r   <= '0;
          stb     <= 1'b1;
          dio_oe  <= 1'b1;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  tm1638_shift #(
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .byte_in   (byte_in_s),
    .dir       (dir_s),
    .sclk      (sclk),
    .dio_out   (dio_out),
    .dio_in    (din_s),
    .byte_out  (rd_data),
    .byte_done (byte_done_s)
  );

endmodule

// File: tb/tb_tm1638_xfer.sv
// Directed self-checking bench for tm1638_xfer at default parameters (CLK_DIV=4).
module tb_tm1638_xfer;
  import tm1638_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [7:0] cmd = 8'h00;
  logic [4:0] len = 5'd0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       dio_in = 1'b1;
  logic       wr_ready, rd_valid, busy, done, stb, sclk, dio_out, dio_oe;
  logic [7:0] rd_data;

  tm1638_xfer dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .cmd(cmd), .len(len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
    .stb(stb), .sclk(sclk), .dio_out(dio_out), .dio_oe(dio_oe), .dio_in(dio_in)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pin monitor: stb-low windows, sclk rises inside them, dio_out at each rise, done and read bytes
  logic       bits_mem [0:4095];
  logic [7:0] rd_mem [0:63];
  int n_bits = 0, n_rd = 0, n_done = 0, n_windows = 0;
  int low_run = 0, win_rises = 0, last_low_len = 0, last_win_rises = 0;
  logic prev_sclk = 1'b1, prev_stb = 1'b1;

  always @(negedge clk) begin
    if (done) n_done++;
    if (rd_valid && n_rd < 64) begin
      rd_mem[n_rd] = rd_data;
      n_rd++;
    end
    if (!stb) begin
      low_run++;
      if (sclk && !prev_sclk) begin
        win_rises++;
        if (n_bits < 4096) begin
          bits_mem[n_bits] = dio_out;
          n_bits++;
        end
      end
    end else if (!prev_stb) begin
      last_low_len   = low_run;
      last_win_rises = win_rises;
      n_windows++;
      low_run   = 0;
      win_rises = 0;
    end
    prev_sclk = sclk;
    prev_stb  = stb;
  end

  function automatic logic [7:0] get_byte(input int base);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = bits_mem[base + i];
    return r;
  endfunction

  task automatic pulse_start(input logic r, input logic [7:0] c, input logic [4:0] l);
    @(posedge clk); #1;
    rw = r; cmd = c; len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called #1 after the start-sampling edge; cyc counts edges from that edge to done
  task automatic wait_done(input string tag, input int budget, output int cyc);
    cyc = 0;
    while (!done && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq({tag, "_done_seen"}, 32'(done), 32'd1);
    check_eq({tag, "_busy_with_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check_eq({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  task automatic run_write(input string tag, input logic [7:0] c, input logic [4:0] l,
                           input int stall, output int n_ready, output int stall_bad);
    int idx, since;
    logic taken;
    n_ready = 0; stall_bad = 0; idx = 0; since = -1;
    wr_data = 8'h00; wr_valid = 1'b1;
    pulse_start(1'b0, c, l);
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      taken = wr_ready;
      if (wr_ready) n_ready++;
      if (since >= 64 && since < 64 + stall && (!sclk || stb || wr_ready)) stall_bad++;
      if (done) break;
      @(posedge clk); #1;
      if (since >= 0) since++;
      if (taken) begin
        idx++;
        wr_data = 8'(idx);
        if (stall > 0 && idx == 1) begin
          wr_valid = 1'b0;
          since = 0;
        end
      end
      if (since == 64 + stall) wr_valid = 1'b1;
    end
    wr_valid = 1'b0;
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  logic [7:0]  key_exp [0:3];
  logic [31:0] key_word;

  initial begin
    int cyc, nr, sb, b0, d0, w0, r0, j, oe_seen, oe_bad;
    logic prev;

    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, nr, sb, b0, d0, w0, r0, j, oe_seen, oe_bad;
    logic prev;
    key_exp[0] = 8'hAA; key_exp[1] = 8'h55; key_exp[2] = 8'h01; key_exp[3] = 8'h80;
    key_word = {key_exp[3], key_exp[2], key_exp[1], key_exp[0]};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ctrl", 32'({stb, sclk, dio_out, dio_oe, busy, done, wr_ready, rd_valid}), 32'h00F0);
    check_eq("rst_rd_data", 32'(rd_data), 32'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Command-only frame
    d0 = n_done; b0 = n_bits;
    pulse_start(1'b0, CMD_DATA_WR_AUTO, 5'd0);
    check_eq("cmd_start_latency", 32'({stb, busy}), 32'h1);
    wait_done("cmd", 300, cyc);
    check_eq("cmd_frame_clocks", 32'(cyc), 32'd76);
    check_eq("cmd_stb_low_len", 32'(last_low_len), 32'd72);
    check_eq("cmd_rises", 32'(last_win_rises), 32'd8);
    check_eq("cmd_bits", 32'(get_byte(b0)), 32'h40);
    check_eq("cmd_done_count", 32'(n_done - d0), 32'd1);

    // Display frame, 16 bytes 00..0F with wr_valid held high
    b0 = n_bits;
    run_write("disp", CMD_ADDR_BASE, 5'd16, 0, nr, sb);
    check_eq("disp_ready_pulses", 32'(nr), 32'd16);
    check_eq("disp_rises", 32'(last_win_rises), 32'd136);
    check_eq("disp_cmd_byte", 32'(get_byte(b0)), 32'hC0);
    for (int i = 0; i < 16; i++)
      check_eq($sformatf("disp_byte%0d", i), 32'(get_byte(b0 + 8 * (i + 1))), 32'(i));

    // Underrun: wr_valid withheld for 50 clocks while the engine waits for byte 2
    b0 = n_bits;
    run_write("urun", CMD_ADDR_BASE, 5'd2, 50, nr, sb);
    check_eq("urun_stall_pins", 32'(sb), 32'd0);
    check_eq("urun_ready_pulses", 32'(nr), 32'd2);
    check_eq("urun_rises", 32'(last_win_rises), 32'd24);
    check_eq("urun_byte0", 32'(get_byte(b0 + 8)), 32'h00);
    check_eq("urun_byte1", 32'(get_byte(b0 + 16)), 32'h01);

    // Oversized len clamps to 16 bytes
    run_write("clamp", CMD_ADDR_BASE, 5'd31, 0, nr, sb);
    check_eq("clamp_ready_pulses", 32'(nr), 32'd16);
    check_eq("clamp_rises", 32'(last_win_rises), 32'd136);

    // Key read: chip returns AA 55 01 80, LSB first, changing on sclk fall
    r0 = n_rd;
    pulse_start(1'b1, CMD_DATA_RD_KEYS, 5'd4);
    cyc = 0; oe_seen = -1; j = 0; oe_bad = 0; prev = sclk;
    for (int t = 0; t < 2000; t++) begin
      @(posedge clk); #1;
      cyc++;
      if (oe_seen < 0 && !dio_oe) oe_seen = cyc;
      if (oe_seen >= 0 && !stb && dio_oe) oe_bad++;
      if (oe_seen >= 0 && prev && !sclk && j < 32) begin
        dio_in = key_word[j];
        j++;
      end
      prev = sclk;
      if (done) break;
    end
    dio_in = 1'b1;
    check_eq("key_done", 32'(done), 32'd1);
    check_eq("key_oe_fall_clock", 32'(oe_seen), 32'd68);
    check_eq("key_oe_stays_low", 32'(oe_bad), 32'd0);
    check_eq("key_read_bits", 32'(j), 32'd32);
    @(posedge clk); #1;
    check_eq("key_rd_count", 32'(n_rd - r0), 32'd4);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("key_rd_byte%0d", i), 32'(rd_mem[r0 + i]), 32'(key_exp[i]));
    check_eq("key_oe_after", 32'(dio_oe), 32'd1);

    // Asynchronous reset in the middle of the command byte
    d0 = n_done;
    wr_valid = 1'b1; wr_data = 8'h5A;
    pulse_start(1'b0, CMD_DATA_WR_AUTO, 5'd2);
    repeat (29) @(posedge clk);
    #2;
    check_eq("pre_rst_pins", 32'({stb, sclk, dio_out}), 32'h0);
    rst = 1'b1;
    #1;
    check_eq("rst_pins", 32'({stb, sclk, dio_oe, dio_out, busy}), 32'h1E);
    wr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b1; cmd = CMD_DATA_WR_AUTO; len = 5'd0; rw = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("start_at_release", 32'({stb, busy}), 32'h2);
    repeat (120) @(posedge clk);
    #1;
    check_eq("rst_no_done", 32'(n_done - d0), 32'd0);

    // Normal frame after reset
    pulse_start(1'b0, CMD_DISP_ON, 5'd0);
    wait_done("post_rst", 300, cyc);
    check_eq("post_rst_frame_clocks", 32'(cyc), 32'd76);
    check_eq("post_rst_stb_low_len", 32'(last_low_len), 32'd72);

    // start while busy is ignored, both mid-frame and in the stb gap
    d0 = n_done; w0 = n_windows; b0 = n_bits;
    pulse_start(1'b0, CMD_DISP_ON, 5'd0);
    repeat (10) @(posedge clk);
    #1;
    start = 1'b1; cmd = 8'hFF; len = 5'd16; rw = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < 200 && !stb; t++) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("gap_busy", 32'(busy), 32'd1);
    wait_done("busy_start", 300, cyc);
    repeat (150) @(posedge clk);
    #1;
    check_eq("busy_start_done_count", 32'(n_done - d0), 32'd1);
    check_eq("busy_start_windows", 32'(n_windows - w0), 32'd1);
    check_eq("busy_start_bits", 32'(get_byte(b0)), 32'h88);
    check_eq("busy_start_idle", 32'({busy, stb}), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
